// File: rtl/core_test_pkg.sv
// Shared types and default sizes for the core test sequencer.
// SEQ_CHECK_MASK_EN adds a per-entry compare mask to check_entry_t.
package core_test_pkg;

  localparam int unsigned XLEN_DEF       = 32;
  localparam int unsigned REG_AW_DEF     = 5;
  localparam int unsigned MAX_CHECKS_DEF = 8;
  localparam int unsigned CNT_W_DEF      = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_REQ,
    S_CMP,
    S_DONE
  } seq_state_e;

  typedef struct packed {
    logic [REG_AW_DEF-1:0] reg_idx;
    logic [XLEN_DEF-1:0]   val;
`ifdef SEQ_CHECK_MASK_EN
    logic [XLEN_DEF-1:0]   mask;
`endif
  } check_entry_t;

endpackage

// File: rtl/core_test_sequencer_check_table.sv
// Expected-value table: synchronous write port, combinational read of one entry.
// Entry layout follows check_entry_t (mask field only with SEQ_CHECK_MASK_EN).
module check_table
  import core_test_pkg::*;
#(
  parameter int unsigned MAX_CHECKS = MAX_CHECKS_DEF
) (
  input  logic                          clk_i,
  input  logic                          we_i,
  input  logic [$clog2(MAX_CHECKS)-1:0] wr_idx_i,
  input  check_entry_t                  wr_entry_i,
  input  logic [$clog2(MAX_CHECKS)-1:0] rd_idx_i,
  output check_entry_t                  rd_entry_c_o
);

  // Contents are deliberately not reset; the table is loaded before use.
  check_entry_t mem_q [MAX_CHECKS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wr_idx_i] <= wr_entry_i;
    end
  end

  assign rd_entry_c_o = mem_q[rd_idx_i];

endmodule

// File: rtl/core_test_sequencer.sv
// Holds the core in reset, lets it run, then walks the expected-value table through
// the register-file probe. SEQ_CHECK_MASK_EN adds cfg_mask_i and masked compares.
module core_test_sequencer
  import core_test_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned REG_AW     = REG_AW_DEF,
  parameter int unsigned MAX_CHECKS = MAX_CHECKS_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            start_i,
  input  logic [CNT_W-1:0]                hold_cycles_i,
  input  logic [CNT_W-1:0]                run_cycles_i,
  input  logic [$clog2(MAX_CHECKS+1)-1:0] num_checks_i,
  input  logic                            cfg_we_i,
  input  logic [$clog2(MAX_CHECKS)-1:0]   cfg_idx_i,
  input  logic [REG_AW-1:0]               cfg_reg_i,
  input  logic [XLEN-1:0]                 cfg_val_i,
`ifdef SEQ_CHECK_MASK_EN
  input  logic [XLEN-1:0]                 cfg_mask_i,
`endif
  output logic                            core_hold_o,
  output logic [REG_AW-1:0]               probe_addr_o,
  input  logic [XLEN-1:0]                 probe_data_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            pass_o,
  output logic [$clog2(MAX_CHECKS)-1:0]   fail_idx_o,
  output logic [XLEN-1:0]                 fail_got_o
);

  localparam int unsigned IDX_W = $clog2(MAX_CHECKS);
  localparam int unsigned NUM_W = $clog2(MAX_CHECKS + 1);

  seq_state_e       state_q;
  logic [CNT_W-1:0] hold_q, run_q, cnt_q;
  logic [NUM_W-1:0] nchk_q;
  logic [IDX_W-1:0] idx_q, rd_idx_c;
  logic [XLEN-1:0]  exp_val_q;
`ifdef SEQ_CHECK_MASK_EN
  logic [XLEN-1:0]  exp_mask_q;
`endif
  check_entry_t     wr_entry_c, rd_entry_c;
  logic             table_we_c, match_c, last_c, hold_last_c, run_end_c;

  always_comb begin
    wr_entry_c         = '0;
    wr_entry_c.reg_idx = cfg_reg_i;
    wr_entry_c.val     = cfg_val_i;
`ifdef SEQ_CHECK_MASK_EN
    wr_entry_c.mask    = cfg_mask_i;
`endif
  end

  assign table_we_c = cfg_we_i && ((state_q == S_IDLE) || (state_q == S_DONE));
  // Entry for the next REQ: 0 when leaving the run phase, i+1 when leaving CMP.
  assign rd_idx_c   = (state_q == S_CMP) ? idx_q + IDX_W'(1) : '0;

  check_table #(.MAX_CHECKS(MAX_CHECKS)) u_table (
    .clk_i       (clk_i),
    .we_i        (table_we_c),
    .wr_idx_i    (cfg_idx_i),
    .wr_entry_i  (wr_entry_c),
    .rd_idx_i    (rd_idx_c),
    .rd_entry_c_o(rd_entry_c)
  );

`ifdef SEQ_CHECK_MASK_EN
  assign match_c = ((probe_data_i ^ exp_val_q) & exp_mask_q) == '0;
`else
  assign match_c = (probe_data_i == exp_val_q);
`endif

  assign last_c      = (NUM_W'(idx_q) + NUM_W'(1)) == nchk_q;
  // A hold length of 0 behaves as 1.
  assign hold_last_c = (hold_q <= CNT_W'(1)) || (cnt_q == hold_q - CNT_W'(1));
  assign run_end_c   = ((state_q == S_HOLD) && hold_last_c && (run_q == '0)) ||
                       ((state_q == S_RUN) && (cnt_q == run_q - CNT_W'(1)));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      hold_q       <= '0;
      run_q        <= '0;
      cnt_q        <= '0;
      nchk_q       <= '0;
      idx_q        <= '0;
      exp_val_q    <= '0;
`ifdef SEQ_CHECK_MASK_EN
      exp_mask_q   <= '0;
`endif
      core_hold_o  <= 1'b1;
      probe_addr_o <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      pass_o       <= 1'b0;
      fail_idx_o   <= '0;
      fail_got_o   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          core_hold_o <= 1'b1;
          if (start_i) begin
            state_q    <= S_HOLD;
            hold_q     <= hold_cycles_i;
            run_q      <= run_cycles_i;
            nchk_q     <= (num_checks_i > NUM_W'(MAX_CHECKS)) ? NUM_W'(MAX_CHECKS) : num_checks_i;
            cnt_q      <= '0;
            idx_q      <= '0;
            busy_o     <= 1'b1;
            done_o     <= 1'b0;
            pass_o     <= 1'b0;
            fail_idx_o <= '0;
            fail_got_o <= '0;
          end
        end
        S_HOLD, S_RUN: begin
          if (run_end_c) begin
            core_hold_o <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= '0;
            if (nchk_q == '0) begin
              state_q <= S_DONE;
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
              pass_o  <= 1'b1;
            end else begin
              state_q      <= S_REQ;
              probe_addr_o <= REG_AW'(rd_entry_c.reg_idx);
              exp_val_q    <= XLEN'(rd_entry_c.val);
`ifdef SEQ_CHECK_MASK_EN
              exp_mask_q   <= XLEN'(rd_entry_c.mask);
`endif
            end
          end else if ((state_q == S_HOLD) && hold_last_c) begin
            state_q     <= S_RUN;
            core_hold_o <= 1'b0;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_REQ: begin
          state_q <= S_CMP;
        end
        S_CMP: begin
          if (!match_c) begin
            state_q    <= S_DONE;
            busy_o     <= 1'b0;
            done_o     <= 1'b1;
            pass_o     <= 1'b0;
            fail_idx_o <= idx_q;
            fail_got_o <= probe_data_i;
          end else if (last_c) begin
            state_q <= S_DONE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            pass_o  <= 1'b1;
          end else begin
            state_q      <= S_REQ;
            idx_q        <= idx_q + IDX_W'(1);
            probe_addr_o <= REG_AW'(rd_entry_c.reg_idx);
            exp_val_q    <= XLEN'(rd_entry_c.val);
`ifdef SEQ_CHECK_MASK_EN
            exp_mask_q   <= XLEN'(rd_entry_c.mask);
`endif
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          core_hold_o <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_test_sequencer.sv
// Self-checking bench for core_test_sequencer: timeline model per sequence, per-cycle compare,
// directed cases plus randomized sequences. Builds with or without SEQ_CHECK_MASK_EN.
module tb_core_test_sequencer;

  localparam int MAXC = 8;

  logic        clk = 1'b0;
  logic        reset, start, cfg_we;
  logic [15:0] hold_cycles, run_cycles;
  logic [3:0]  num_checks;
  logic [2:0]  cfg_idx;
  logic [4:0]  cfg_reg;
  logic [31:0] cfg_val, cfg_mask;
  logic        core_hold, busy, done, pass;
  logic [4:0]  probe_addr;
  logic [31:0] probe_data;
  logic [2:0]  fail_idx;
  logic [31:0] fail_got;

  always #5 clk = ~clk;

  core_test_sequencer dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .start_i      (start),
    .hold_cycles_i(hold_cycles),
    .run_cycles_i (run_cycles),
    .num_checks_i (num_checks),
    .cfg_we_i     (cfg_we),
    .cfg_idx_i    (cfg_idx),
    .cfg_reg_i    (cfg_reg),
    .cfg_val_i    (cfg_val),
`ifdef SEQ_CHECK_MASK_EN
    .cfg_mask_i   (cfg_mask),
`endif
    .core_hold_o  (core_hold),
    .probe_addr_o (probe_addr),
    .probe_data_i (probe_data),
    .busy_o       (busy),
    .done_o       (done),
    .pass_o       (pass),
    .fail_idx_o   (fail_idx),
    .fail_got_o   (fail_got)
  );

  // Register file seen by the probe: synchronous read, data one cycle after the address.
  logic [31:0] rf [32];
  always @(posedge clk) probe_data <= rf[probe_addr];

  logic [4:0]  tbl_reg  [MAXC];
  logic [31:0] tbl_val  [MAXC];
  logic [31:0] tbl_mask [MAXC];

  int checks = 0, errors = 0;
  int t = 0, first_done = -1, hold_cnt = 0;
  bit mon_en = 0, mon_fin = 0;
  int m_H, m_R, m_k, m_L, m_fidx;
  bit m_pass;
  logic [31:0] m_fgot;
  logic [4:0]  m_pa0, pa_prev;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0d, time %0t)", name, got, exp, t, $time);
    end
  endtask

  function automatic bit bench_match(input logic [31:0] got, input int j);
`ifdef SEQ_CHECK_MASK_EN
    return ((got ^ tbl_val[j]) & tbl_mask[j]) == 32'd0;
`else
    return got == tbl_val[j];
`endif
  endfunction

  // Compare process: t counts clock edges since the start edge; outputs follow from the timeline.
  always begin
    @(posedge clk);
    #2;
    if (!mon_en) begin
      t = 0;
      mon_fin = 0;
    end else begin
      if (t == 0) begin
        first_done = -1;
        hold_cnt = 0;
      end
      t++;
      if (done && first_done < 0) first_done = t;
      if (core_hold && busy) hold_cnt++;
      chk("busy", 32'(busy), 32'(t < m_L));
      chk("done", 32'(done), 32'(t >= m_L));
      chk("core_hold", 32'(core_hold), 32'((t <= m_H) || (t > m_L)));
      chk("pass", 32'(pass), (t >= m_L) ? 32'(m_pass) : 32'd0);
      chk("fail_idx", 32'(fail_idx), (t >= m_L) ? 32'(m_fidx) : 32'd0);
      chk("fail_got", fail_got, (t >= m_L) ? m_fgot : 32'd0);
      if (t > m_H + m_R && t < m_L)
        chk("probe_addr", 32'(probe_addr), 32'(tbl_reg[(t - m_H - m_R - 1) / 2]));
      else if (t >= m_L && m_k > 0)
        chk("probe_addr", 32'(probe_addr), 32'(tbl_reg[m_k - 1]));
      else
        chk("probe_addr", 32'(probe_addr), 32'(m_pa0));
      mon_fin = (t >= m_L + 1);
    end
  end

  task automatic wr_entry(input int idx, input logic [4:0] rg, input logic [31:0] v, input logic [31:0] m);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_reg = rg; cfg_val = v; cfg_mask = m;
    tbl_reg[idx] = rg; tbl_val[idx] = v; tbl_mask[idx] = m;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic run_seq(input int h, input int r, input int n, input bit inject);
    int hh, ne, k, fidx, cyc;
    bit ps;
    logic [31:0] got, fgot;
    hh = (h == 0) ? 1 : h;
    ne = (n > MAXC) ? MAXC : n;
    k = 0; ps = 1; fidx = 0; fgot = 0;
    for (int j = 0; j < ne; j++) begin
      got = rf[tbl_reg[j]];
      k = j + 1;
      if (!bench_match(got, j)) begin
        ps = 0; fidx = j; fgot = got;
        break;
      end
    end
    m_H = hh; m_R = r; m_k = k; m_L = hh + r + 2 * k + 1;
    m_pass = ps; m_fidx = fidx; m_fgot = fgot; m_pa0 = pa_prev;
    @(negedge clk);
    start = 1'b1; hold_cycles = 16'(h); run_cycles = 16'(r); num_checks = 4'(n);
    mon_en = 1;
    @(negedge clk);
    start = 1'b0; hold_cycles = 16'($urandom); run_cycles = 16'($urandom); num_checks = 4'($urandom);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (inject && cyc == hh + 1) begin
        start = 1'b1; cfg_we = 1'b1; cfg_idx = 3'd0;
        cfg_reg = tbl_reg[0] ^ 5'd1; cfg_val = ~tbl_val[0]; cfg_mask = 32'hFFFF_FFFF;
      end else begin
        start = 1'b0; cfg_we = 1'b0;
      end
      if (mon_fin) break;
      if (cyc > 2000) begin
        errors++;
        $display("FAIL seq_timeout: no done after %0d cycles, expected %0d", cyc, m_L);
        break;
      end
    end
    mon_en = 0; start = 1'b0; cfg_we = 1'b0;
    if (k > 0) pa_prev = tbl_reg[k - 1];
  endtask

  initial begin
    logic [4:0] rg;
    logic [31:0] v, m;
    for (int i = 0; i < 32; i++) rf[i] = 32'($urandom);
    reset = 1'b1; start = 1'b0; cfg_we = 1'b0;
    hold_cycles = '0; run_cycles = '0; num_checks = '0;
    cfg_idx = '0; cfg_reg = '0; cfg_val = '0; cfg_mask = '0;
    pa_prev = '0;
    repeat (3) @(negedge clk);
    chk("rst_core_hold", 32'(core_hold), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_fail_idx", 32'(fail_idx), 32'd0);
    chk("rst_fail_got", fail_got, 32'd0);
    chk("rst_probe_addr", 32'(probe_addr), 32'd0);
    reset = 1'b0;

    // Basic pass: hold 3, run 2, x1=24, x2=30.
    wr_entry(0, 5'd1, 32'd24, 32'hFFFF_FFFF);
    wr_entry(1, 5'd2, 32'd30, 32'hFFFF_FFFF);
    rf[1] = 32'd24; rf[2] = 32'd30;
    run_seq(3, 2, 2, 0);
    chk("t1_pass", 32'(pass), 32'd1);
    chk("t1_done_latency", 32'(first_done), 32'd10);
    chk("t1_hold_cycles", 32'(hold_cnt), 32'd3);

    // Mismatch on the second entry.
    rf[2] = 32'd31;
    run_seq(3, 2, 2, 0);
    chk("t2_pass", 32'(pass), 32'd0);
    chk("t2_fail_idx", 32'(fail_idx), 32'd1);
    chk("t2_fail_got", fail_got, 32'h0000_001F);

    // No entries: straight to done with pass, probe untouched.
    run_seq(2, 5, 0, 0);
    chk("t3_pass", 32'(pass), 32'd1);
    chk("t3_probe_addr", 32'(probe_addr), 32'd2);

    // start and cfg_we pulsed during RUN are ignored; table keeps old entry 0.
    rf[2] = 32'd30;
    run_seq(1, 6, 2, 1);
    chk("t4_pass", 32'(pass), 32'd1);
    run_seq(0, 0, 2, 0);
    chk("t4_table_kept", 32'(pass), 32'd1);

    // Count above table depth is clamped.
    for (int j = 2; j < MAXC; j++) begin
      wr_entry(j, 5'(j + 3), 32'(j * 7), 32'hFFFF_FFFF);
      rf[j + 3] = 32'(j * 7);
    end
    run_seq(1, 1, 12, 0);
    chk("t5_clamp_pass", 32'(pass), 32'd1);

    // Reset during RUN.
    @(negedge clk);
    start = 1'b1; hold_cycles = 16'd2; run_cycles = 16'd10; num_checks = 4'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_in_run_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_core_hold", 32'(core_hold), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_probe_addr", 32'(probe_addr), 32'd0);
    pa_prev = '0;
    run_seq(1, 1, 1, 0);

    // Masked compare: only the low byte matters when the mask feature is built in.
    wr_entry(0, 5'd3, 32'h0000_001E, 32'h0000_00FF);
    rf[3] = 32'hABCD_001E;
    run_seq(1, 0, 1, 0);
`ifdef SEQ_CHECK_MASK_EN
    chk("t7_mask_pass", 32'(pass), 32'd1);
`else
    chk("t7_mask_pass", 32'(pass), 32'd0);
`endif

    // Randomized sequences.
    for (int s = 0; s < 25; s++) begin
      for (int j = 0; j < MAXC; j++) begin
        rg = 5'($urandom_range(1, 31));
        v = 32'($urandom);
        m = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
        wr_entry(j, rg, v, m);
      end
      for (int j = 0; j < MAXC; j++) begin
        if ($urandom_range(0, 5) == 0) rf[tbl_reg[j]] = tbl_val[j] ^ 32'($urandom);
        else rf[tbl_reg[j]] = tbl_val[j];
      end
      run_seq($urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 15), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
